// File: rtl/seven_segment_pkg.sv
// Shared seven-segment glyph table and decode helper, reused by single- and
// multi-digit display drivers.
package seven_segment_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-high patterns {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    return SEG_LUT[n];
  endfunction

endpackage

// File: rtl/seven_segment.sv
// Registered hex-to-seven-segment decoder for one digit; outputs come straight
// from flops, one clock after the nibble is sampled.
module seven_segment
  import seven_segment_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);

  // All segments dark in the selected polarity.
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? '1 : '0;

  logic [6:0] seg_d;
  logic [6:0] seg_q;

  always_comb begin
    seg_d = hex_to_seg({A, B, C, D});
    if (ACTIVE_LOW) begin
      seg_d = ~seg_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_OFF;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign a = seg_q[SEG_A];
  assign b = seg_q[SEG_B];
  assign c = seg_q[SEG_C];
  assign d = seg_q[SEG_D];
  assign e = seg_q[SEG_E];
  assign f = seg_q[SEG_F];
  assign g = seg_q[SEG_G];

endmodule

// File: tb/tb_seven_segment.sv
// Directed + random bench for seven_segment, both polarities side by side,
// checked against a glyph model described by lit-segment letters.
module tb_seven_segment;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic reset = 1'b0;
  logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic ha, hb, hc, hd, he, hf, hg;
  logic la, lb, lc, ld, le, lf, lg;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [6:0] prev_exp;

  seven_segment #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .A(A), .B(B), .C(C), .D(D),
    .a(ha), .b(hb), .c(hc), .d(hd), .e(he), .f(hf), .g(hg)
  );

  seven_segment #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .A(A), .B(B), .C(C), .D(D),
    .a(la), .b(lb), .c(lc), .d(ld), .e(le), .f(lf), .g(lg)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Which segments each glyph lights, written as letters a..g.
  string glyphs [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] p;
    string s;
    p = '0;
    s = glyphs[n];
    for (int i = 0; i < s.len(); i++) begin
      p[int'(s[i]) - 97] = 1'b1;
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [6:0] exp_hi);
    logic [6:0] obs_hi, obs_lo;
    obs_hi = {hg, hf, he, hd, hc, hb, ha};
    obs_lo = {lg, lf, le, ld, lc, lb, la};
    vectors++;
    assert (obs_hi === exp_hi) else begin
      miscompares++;
      $error("FAIL %s active-high: got %b expected %b", tag, obs_hi, exp_hi);
    end
    vectors++;
    assert (obs_lo === ~exp_hi) else begin
      miscompares++;
      $error("FAIL %s active-low: got %b expected %b", tag, obs_lo, ~exp_hi);
    end
  endtask

  // Drive at the falling edge, confirm the old glyph still shows, then
  // confirm the new glyph appears just after the next rising edge.
  task automatic apply(input string tag, input logic [3:0] n);
    @(negedge clk);
    {A, B, C, D} = n;
    #1 check({tag, "_hold"}, prev_exp);
    @(posedge clk);
    #1 check(tag, glyph(n));
    prev_exp = glyph(n);
  endtask

  initial begin
    // Reset with no clock running must blank immediately.
    #3 reset = 1'b1;
    #1 check("reset_noclk", 7'b0000000);

    clk_en = 1'b1;
    {A, B, C, D} = 4'h8;
    repeat (3) @(posedge clk);
    #1 check("reset_held_clk", 7'b0000000);

    @(negedge clk);
    reset = 1'b0;
    prev_exp = 7'b0000000;
    #1 check("reset_release", 7'b0000000);
    @(posedge clk);
    #1 check("first_edge", glyph(4'h8));
    prev_exp = glyph(4'h8);

    for (int i = 0; i < 16; i++) begin
      apply("sweep", 4'(i));
    end

    for (int i = 0; i < 8; i++) begin
      apply("alt", (i % 2 == 0) ? 4'h1 : 4'h8);
    end

    for (int i = 0; i < 40; i++) begin
      apply("rand", 4'($urandom_range(0, 15)));
    end

    // Mid-stream reset pulse between edges.
    apply("pre_rst", 4'h8);
    @(negedge clk);
    reset = 1'b1;
    #1 check("midrst_async", 7'b0000000);
    @(posedge clk);
    #1 check("midrst_held", 7'b0000000);
    @(negedge clk);
    reset = 1'b0;
    #1 check("midrst_release", 7'b0000000);
    @(posedge clk);
    #1 check("midrst_restore", 7'h7F);
    prev_exp = 7'h7F;

    apply("post_b", 4'hB);
    apply("post_0", 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_segment.md
# seven_segment

Registered hexadecimal-to-seven-segment decoder. It takes a 4-bit nibble on four scalar inputs (A = MSB … D = LSB) and drives the seven segment lines a–g of a single common digit with the glyph for 0–9, A, b, C, d, E, F. It sits between a nibble source (counter, register, switches) and the display pins, one instance per digit.

## Interface
Parameters:
- ACTIVE_LOW, default 0: segment polarity; 0 means 1 = segment lit (common cathode), 1 means all outputs are inverted (common anode).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- A  input  1  nibble bit 3 (MSB).
- B  input  1  nibble bit 2.
- C  input  1  nibble bit 1.
- D  input  1  nibble bit 0 (LSB).
- a, b, c, d, e, f, g  output  1 each  segment drives: a top, b top-right, c bottom-right, d bottom, e bottom-left, f top-left, g middle.

One clock domain; reset is asynchronous and active-high.

## Operation
- Form the nibble N = {A,B,C,D}. Decode N to the 7-bit pattern P = {g,f,e,d,c,b,a} in active-high polarity:
  - 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07.
  - 8→0x7F, 9→0x6F, A→0x77, b→0x7C, C→0x39, d→0x5E, E→0x79, F→0x71.
- Glyphs 6 and 9 include their tails (segment a on 6, segment d on 9). Glyphs 7 and 1 are three and two segments respectively.
- Output register R <= P when ACTIVE_LOW = 0, and R <= ~P when ACTIVE_LOW = 1. Ports a..g are driven directly from R, bit 0 = a through bit 6 = g.
- All 16 codes are legal; there is no blanking state and no error state.
- X/Z on any input produces X on the outputs in simulation only; no special handling.

## Timing
- Latency: 1 clock. The input sampled at rising edge k appears on a..g after edge k and holds until edge k+1.
- Reset asserted: R goes to all-segments-off immediately, without waiting for a clock edge. This is 7'b0000000 with ACTIVE_LOW = 0 and 7'b1111111 with ACTIVE_LOW = 1.
- While reset is held, clock edges are ignored.
- On reset release, the first rising edge loads the decode of the current N.
- Reset asserted mid-stream discards the pending value; there is no recovery of the previous glyph.
- Inputs may change every cycle; each cycle's value is shown exactly one cycle later.
- No handshake.
- Outputs are glitch-free because they come straight from flops.

## Structure
- Package seven_segment_pkg contains:
  - the localparam array SEG_LUT[16] of 7-bit active-high patterns listed above;
  - named index constants SEG_A=0 … SEG_G=6;
  - a function hex_to_seg(logic [3:0]) returning SEG_LUT[n].
- No sub-module: the decode is the package function feeding a single always_ff with async reset.
- Other display blocks (multiplexed multi-digit drivers) reuse the package.

## Test plan
- Reset: assert reset with no clock running → a..g = 0000000 immediately. With ACTIVE_LOW = 1 → 1111111.
- Full sweep: after reset release, apply N = 0x0…0xF, one value per cycle. Each output one cycle later must equal the table, e.g. 0→{g..a}=0111111, 1→0000110, 8→1111111, F→1110001.
- Latency and back-to-back: alternate N = 0x1, 0x8 every cycle → outputs alternate 0x06 / 0x7F, delayed exactly one cycle with no skipped or duplicated value.
- Mid-stream reset: hold N = 0x8, outputs 0x7F; pulse reset between clock edges → outputs 0x00 at once. After release, the next edge restores 0x7F.
- Polarity: instance with ACTIVE_LOW = 1 and the same sweep → every output is the bitwise inverse, e.g. 0→1000000, b→0000011.
